// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator.
// Single clock domain; the pixel rate is set by a clock-enable strobe.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               pclk_en,
  output logic               h_sync,
  output logic               v_sync,
  output logic               DE,
  output logic [CNT_W-1:0]   x_pixel,
  output logic [CNT_W-1:0]   y_pixel,
  output logic               pix_stb,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW1     = CNT_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  localparam logic [CW1-1:0] H_ACT  = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0] V_ACT  = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0] HS_BEG = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW1-1:0] HS_END = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW1-1:0] VS_BEG = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW1-1:0] VS_END = CW1'(V_ACTIVE + V_FP + V_SYNC);

  if (CLK_DIV < 1 || CNT_W < 1 || FRAME_W < 1 ||
      H_ACTIVE < 1 || H_SYNC < 1 ||
      V_ACTIVE < 1 || V_SYNC < 1 ||
      H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0 ||
      H_TOTAL > (2 ** CNT_W) ||
      V_TOTAL > (2 ** CNT_W)) begin : g_bad_params
    $error("vga_timing_gen: illegal parameter set");
  end

  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   v_q, v_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               de_q, de_d;
  logic [CNT_W-1:0]   x_q;
  logic [CNT_W-1:0]   y_q;
  logic               stb_q;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;
  logic [FRAME_W-1:0] fc_q;
  logic               div_wrap;
  logic               h_wrap;
  logic [CW1-1:0]     hw, vw;

  assign div_wrap = (div_q == DIV_LAST);
  assign pclk_en  = en && div_wrap;

  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = div_wrap ? '0 : div_q + 1'b1;
    end
  end

  // Next raster position; only committed on a pixel advance.
  assign h_wrap = (h_q == H_LAST);

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_wrap) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  assign hw = {1'b0, h_d};
  assign vw = {1'b0, v_d};

  always_comb begin
    hs_d = ~H_SYNC_POL;
    vs_d = ~V_SYNC_POL;
    if (hw >= HS_BEG && hw < HS_END) begin
      hs_d = H_SYNC_POL;
    end
    if (vw >= VS_BEG && vw < VS_END) begin
      vs_d = V_SYNC_POL;
    end
    de_d = (hw < H_ACT) && (vw < V_ACT);
    ls_d = pclk_en && (h_d == '0);
    fs_d = ls_d && (v_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= H_LAST;
      v_q   <= V_LAST;
      hs_q  <= ~H_SYNC_POL;
      vs_q  <= ~V_SYNC_POL;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      stb_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      fc_q  <= '0;
    end else begin
      div_q <= div_d;
      stb_q <= pclk_en;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      if (pclk_en) begin
        h_q  <= h_d;
        v_q  <= v_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
        x_q  <= h_d;
        y_q  <= v_d;
      end
      if (fs_d) begin
        fc_q <= fc_q + 1'b1;
      end
    end
  end

  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign DE          = de_q;
  assign x_pixel     = x_q;
  assign y_pixel     = y_q;
  assign pix_stb     = stb_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/DVI raster timing generator. It replaces the fixed 640x480 divide-by-4 timing chain with a single-clock design. Instead of a derived pixel clock it emits a pixel-clock-enable strobe, and it supports configurable timing, sync polarity, run/stop control, line/frame strobes and a frame counter. It sits between the system clock domain and the pixel pipeline (pattern/camera compositor, HDMI/VGA output).

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
H_SYNC_POL, 0, 1 = active-high h_sync, 0 = active-low
V_SYNC_POL, 0, 1 = active-high v_sync, 0 = active-low
CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
FRAME_W, 8, frame counter width

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high
en  input  1  run enable; 0 freezes divider, counters and outputs
pclk_en  output  1  one-clk pulse every CLK_DIV clks while en=1 (combinational from divider register)
h_sync  output  1  horizontal sync, polarity per H_SYNC_POL, registered
v_sync  output  1  vertical sync, polarity per V_SYNC_POL, registered
DE  output  1  display enable (visible area), registered
x_pixel  output  CNT_W  current horizontal count, registered
y_pixel  output  CNT_W  current vertical count, registered
pix_stb  output  1  one-clk pulse: outputs just advanced to a new pixel
line_start  output  1  one-clk pulse with pix_stb when new x_pixel==0
frame_start  output  1  one-clk pulse with pix_stb when new x_pixel==0 and y_pixel==0
frame_cnt  output  FRAME_W  frames started since reset, wraps modulo 2^FRAME_W

Behaviour:
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (sync, priority over en):
  - div_cnt=0.
  - h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, so the first advance lands on (0,0).
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL.
  - DE=0, x_pixel=0, y_pixel=0, pix_stb=0, line_start=0, frame_start=0, frame_cnt=0.
- Divider:
  - en=1: div_cnt counts 0..CLK_DIV-1 and wraps. pclk_en=(div_cnt==CLK_DIV-1)&&en.
  - First pclk_en occurs in the CLK_DIV-th clk after reset release with en=1.
  - CLK_DIV=1: pclk_en=en constantly.
- Counters (update only on the edge ending a pclk_en cycle):
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt at V_TOTAL-1 with h_cnt at H_TOTAL-1 wraps to 0.
  - No other wrap points.
- Output stage:
  - Loads on the same edge as the counters, decoding the next counter values (hn,vn). Output latency is therefore 0 clk relative to the counter update.
  - pix_stb is pclk_en delayed 1 clk.
  - Outputs hold between loads.
- Decode:
  - h_sync active iff H_ACTIVE+H_FP <= hn < H_ACTIVE+H_FP+H_SYNC.
  - v_sync active iff V_ACTIVE+V_FP <= vn < V_ACTIVE+V_FP+V_SYNC.
  - Active level equals the POL parameter; otherwise the inverse.
  - DE = (hn<H_ACTIVE)&&(vn<V_ACTIVE).
  - x_pixel=hn, y_pixel=vn. Raw counts are also driven during blanking.
- Strobes:
  - line_start and frame_start are registered with the output stage and are high only in the pix_stb cycle.
  - frame_start has no other qualifier.
  - frame_cnt increments on the edge that sets frame_start and wraps silently.
- en deasserted:
  - div_cnt, counters and all level outputs hold.
  - pclk_en, pix_stb, line_start and frame_start are 0 from the next clk (pix_stb may still complete a pulse already registered).
  - Re-assert resumes from the held div_cnt with no skipped or repeated pixel.
- Reset mid-frame: the next clk shows reset values. Timing restarts exactly as after power-up.
- No overflow condition exists. The parameter check (CNT_W wide enough, all widths >=1) is an elaboration-time assertion.

Test Plan:
- Defaults, en=1 after reset -> pclk_en every 4th clk, first pulse in clk 4. pix_stb follows 1 clk later with x=0, y=0, DE=1, line_start=1, frame_start=1, frame_cnt=1.
- Run to end of line 0 -> x 639 DE=1; x 640 DE=0. h_sync low for x 656..751 inclusive (96 pixels), high elsewhere. At x 799->0 y=1 with line_start=1 and frame_start=0.
- Run a full frame -> v_sync low only for y 490..491. After y 524 x 799 the next pixel is (0,0) with frame_start=1 and frame_cnt=2. Frame period is 420000 pixels / 1680000 clks.
- en=0 for 37 clks at x=100,y=5, then en=1 -> no pclk_en/pix_stb while low. Next pixel is x=101,y=5; timing is otherwise contiguous.
- reset pulse at x=300,y=200 -> next clk h_sync=1, v_sync=1, DE=0, frame_cnt=0. First pixel after release is (0,0) with frame_start.
- Variant CLK_DIV=1, H_SYNC_POL=1, V_SYNC_POL=1, FRAME_W=2 -> pclk_en constantly high. h_sync high only for x 656..751. frame_cnt sequence 1,2,3,0 over 4 frames.
